tile_renderer: RTL and testbench
================================

TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have parameter TILE_W, default 16, meaning tile width in pixels.
REQ-002 SHALL have parameter TILE_H, default 12, meaning tile height in pixels.
REQ-003 SHALL have parameter GRID_COLS, default 10, meaning number of valid grid columns.
REQ-004 SHALL have parameter GRID_ROWS, default 10, meaning number of valid grid rows.
REQ-005 SHALL have parameters X_W, default 8, and Y_W, default 7, meaning pixel coordinate widths.
REQ-006 SHALL have parameter COLOUR_W, default 3, meaning colour width.
REQ-007 SHALL have port clock, input, 1, meaning the only clock; all logic on posedge.
REQ-008 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, meaning request to draw one cell.
REQ-010 SHALL have port address, input, 8, meaning cell location: [7:4] row, [3:0] column.
REQ-011 SHALL have port position, input, 8, meaning cell content code.
REQ-012 SHALL have port busy, output, 1, meaning a request is in progress.
REQ-013 SHALL have port plot, output, 1, meaning the x/y/colour outputs are a valid pixel write this cycle.
REQ-014 SHALL have ports x, output, X_W, and y, output, Y_W, meaning pixel coordinate.
REQ-015 SHALL have port colour, output, COLOUR_W, meaning pixel colour.
REQ-016 SHALL have ports done and err, output, 1 each, meaning one-cycle completion pulse and out-of-range flag.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, DRAW and DONE.
REQ-018 SHALL, in IDLE with start=1, latch address and position, assert busy and go to LOAD next cycle; start SHALL be ignored in every other state.
REQ-019 SHALL, in LOAD, compute origin_x = col*TILE_W and origin_y = row*TILE_H, then select shape (offset, width, height, colour) from the latched position.
REQ-020 SHALL use these shapes: wall 8'b1000_0000 -> full tile, colour 3'b011; tank1 8'b0100_0000 -> 8x8 at offset ((TILE_W-8)/2, (TILE_H-8)/2), colour 3'b101; tank2 8'b0010_0000 -> same geometry, colour 3'b100.
REQ-021 SHALL use these further shapes: horizontal projectile 8'b0001_0100 -> TILE_W x 2 at y offset TILE_H/2-1, colour 3'b110; vertical projectile 8'b0001_1000 -> 2 x TILE_H at x offset TILE_W/2-1, colour 3'b110; any other code -> full tile, colour 0 (erase).
REQ-022 SHALL, in DRAW, emit exactly one pixel per cycle with plot=1, scanning x fastest then y, from (origin+offset) to (origin+offset+size-1).
REQ-023 SHALL go to DONE the cycle after the last pixel; DONE SHALL assert done=1 for exactly one cycle and then return to IDLE with busy=0.
REQ-024 SHALL give latency as follows: start accepted at cycle 0, first plot at cycle 2, done at cycle 2+W*H, where W*H is the shape area.
REQ-025 SHALL, if row>=GRID_ROWS or col>=GRID_COLS, skip DRAW (zero plots) and go LOAD -> DONE with err=1 and done=1 in the same cycle.
REQ-026 SHALL hold plot=0 outside DRAW; x, y and colour SHALL hold their last values when plot=0.
REQ-027 SHALL compute coordinate arithmetic at X_W/Y_W width; parameters SHALL guarantee GRID_COLS*TILE_W <= 2^X_W and GRID_ROWS*TILE_H <= 2^Y_W (elaboration check).

Reset
REQ-028 SHALL, with reset=1, on the next edge force state to IDLE and busy, plot, done, err, x, y and colour to 0, abandoning any draw in progress without a done pulse.
REQ-029 SHALL give reset priority over a simultaneous start.

Structure
REQ-030 SHALL place the cell codes, shape colours and FSM state encoding in a shared package tile_pkg.
REQ-031 SHALL use one sub-module, pixel_scanner: a 2D counter loaded with width and height, advanced by an enable, outputting px, py and last.

Verification
REQ-032 SHALL test wall at 8'h23: 192 plots from (48,24) to (63,35), colour 3'b011, done at cycle 194.
REQ-033 SHALL test tank1 at 8'h00: 64 plots from (4,2) to (11,9), colour 3'b101; tank2 at 8'h00 gives the same geometry with colour 3'b100.
REQ-034 SHALL test horizontal projectile at 8'h11: 32 plots, x 16..31, y 17..18, colour 3'b110.
REQ-035 SHALL test address 8'hA0: zero plots, done=1 and err=1 at cycle 2.
REQ-036 SHALL test start pulsed while busy as ignored, and reset at the 10th plot as giving plot=0 and busy=0 the next cycle with no done pulse.
REQ-037 SHALL test unknown code 8'h01 at 8'h99 as an erase: 192 plots, colour 0, from (144,108) to (159,119).

Source files
------------

// File: rtl/tile_pkg.sv
// tile_pkg -- shared definitions for the tile renderer.
//   Cell content codes, the colour drawn for each shape, and the
//   renderer FSM state encoding.
package tile_pkg;

    // Cell content codes carried on the position input
    localparam logic [7:0] CODE_WALL  = 8'b1000_0000;
    localparam logic [7:0] CODE_TANK1 = 8'b0100_0000;
    localparam logic [7:0] CODE_TANK2 = 8'b0010_0000;
    localparam logic [7:0] CODE_HPROJ = 8'b0001_0100;
    localparam logic [7:0] CODE_VPROJ = 8'b0001_1000;

    // Shape colours
    localparam logic [2:0] COL_WALL  = 3'b011;
    localparam logic [2:0] COL_TANK1 = 3'b101;
    localparam logic [2:0] COL_TANK2 = 3'b100;
    localparam logic [2:0] COL_PROJ  = 3'b110;
    localparam logic [2:0] COL_ERASE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_scanner.sv
// pixel_scanner -- 2D raster counter.
//   clock, reset : clock and synchronous active-high reset
//   load         : restart at (0,0) and capture width/height
//   width/height : rectangle size in pixels (at least 1 each)
//   enable       : advance one pixel, x fastest then y
//   px, py       : current offset inside the rectangle
//   last         : current offset is the final pixel of the rectangle
module pixel_scanner #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [XW:0]   width,
    input  logic [YW:0]   height,
    input  logic          enable,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic          last
);

    localparam logic [XW:0]   ONE_WX = 1;
    localparam logic [YW:0]   ONE_WY = 1;
    localparam logic [XW-1:0] ONE_X  = 1;
    localparam logic [YW-1:0] ONE_Y  = 1;

    logic [XW:0] w_q;
    logic [YW:0] h_q;
    logic        x_end;
    logic        y_end;

    // Sizes are one wider than the counters so a full-width span fits
    assign x_end = ({1'b0, px} == (w_q - ONE_WX));
    assign y_end = ({1'b0, py} == (h_q - ONE_WY));
    assign last  = x_end && y_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (load) begin
            px <= '0;
            py <= '0;
        end else if (enable) begin
            if (x_end) begin
                px <= '0;
                py <= py + ONE_Y;
            end else begin
                px <= px + ONE_X;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (load) begin
            w_q <= width;
            h_q <= height;
        end
    end

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer -- draws one grid cell as a stream of pixel writes.
//   clock, reset     : clock and synchronous active-high reset
//   start            : request to draw one cell (accepted only when idle)
//   address          : [7:4] row, [3:0] column of the cell
//   position         : cell content code, selects the shape drawn
//   busy             : a request is in progress
//   plot             : x/y/colour are a valid pixel write this cycle
//   x, y, colour     : pixel coordinate and colour (held while plot=0)
//   done             : one-cycle completion pulse
//   err              : with done, the cell address was off the grid
module tile_renderer
    import tile_pkg::*;
#(
    parameter int TILE_W    = 16,
    parameter int TILE_H    = 12,
    parameter int GRID_COLS = 10,
    parameter int GRID_ROWS = 10,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          address,
    input  logic [7:0]          position,
    output logic                busy,
    output logic                plot,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                done,
    output logic                err
);

    generate
        if (GRID_COLS * TILE_W > 2 ** X_W) begin : g_bad_x
            $error("tile_renderer: GRID_COLS*TILE_W exceeds 2**X_W");
        end
        if (GRID_ROWS * TILE_H > 2 ** Y_W) begin : g_bad_y
            $error("tile_renderer: GRID_ROWS*TILE_H exceeds 2**Y_W");
        end
    endgenerate

    // Shape geometry constants
    localparam logic [X_W:0]   FULL_W  = (X_W+1)'(TILE_W);
    localparam logic [Y_W:0]   FULL_H  = (Y_W+1)'(TILE_H);
    localparam logic [X_W:0]   TANK_W  = (X_W+1)'(8);
    localparam logic [Y_W:0]   TANK_H  = (Y_W+1)'(8);
    localparam logic [X_W:0]   PROJ_W  = (X_W+1)'(2);
    localparam logic [Y_W:0]   PROJ_H  = (Y_W+1)'(2);
    localparam logic [X_W-1:0] TANK_OX = X_W'((TILE_W - 8) / 2);
    localparam logic [Y_W-1:0] TANK_OY = Y_W'((TILE_H - 8) / 2);
    localparam logic [X_W-1:0] VPROJ_OX = X_W'(TILE_W / 2 - 1);
    localparam logic [Y_W-1:0] HPROJ_OY = Y_W'(TILE_H / 2 - 1);

    state_t state;
    state_t state_nxt;

    logic [7:0]          addr_q;
    logic [7:0]          pos_q;
    logic [3:0]          row;
    logic [3:0]          col;
    logic                oob;
    logic [X_W-1:0]      origin_x;
    logic [Y_W-1:0]      origin_y;

    logic [X_W-1:0]      offs_x;
    logic [Y_W-1:0]      offs_y;
    logic [X_W:0]        shp_w;
    logic [Y_W:0]        shp_h;
    logic [COLOUR_W-1:0] shp_c;

    logic [X_W-1:0]      base_x;
    logic [Y_W-1:0]      base_y;
    logic [COLOUR_W-1:0] colour_q;
    logic                err_q;

    logic [X_W-1:0]      px;
    logic [Y_W-1:0]      py;
    logic                scan_last;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;

    logic [X_W-1:0]      x_hold;
    logic [Y_W-1:0]      y_hold;
    logic [COLOUR_W-1:0] colour_hold;

    assign row = addr_q[7:4];
    assign col = addr_q[3:0];
    assign oob = (32'(row) >= GRID_ROWS) || (32'(col) >= GRID_COLS);

    // Off-grid cells may overflow here; the result is never used for them
    assign origin_x = X_W'(32'(col) * TILE_W);
    assign origin_y = Y_W'(32'(row) * TILE_H);

    // Shape selection from the latched content code
    always_comb begin
        offs_x = '0;
        offs_y = '0;
        shp_w  = FULL_W;
        shp_h  = FULL_H;
        shp_c  = COLOUR_W'(COL_ERASE);
        case (pos_q)
            CODE_WALL: begin
                shp_c = COLOUR_W'(COL_WALL);
            end
            CODE_TANK1: begin
                offs_x = TANK_OX;
                offs_y = TANK_OY;
                shp_w  = TANK_W;
                shp_h  = TANK_H;
                shp_c  = COLOUR_W'(COL_TANK1);
            end
            CODE_TANK2: begin
                offs_x = TANK_OX;
                offs_y = TANK_OY;
                shp_w  = TANK_W;
                shp_h  = TANK_H;
                shp_c  = COLOUR_W'(COL_TANK2);
            end
            CODE_HPROJ: begin
                offs_y = HPROJ_OY;
                shp_h  = PROJ_H;
                shp_c  = COLOUR_W'(COL_PROJ);
            end
            CODE_VPROJ: begin
                offs_x = VPROJ_OX;
                shp_w  = PROJ_W;
                shp_c  = COLOUR_W'(COL_PROJ);
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = oob ? DONE : DRAW;
            DRAW:    if (scan_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; start outside IDLE never reaches these registers
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            addr_q <= address;
            pos_q  <= position;
        end
    end

    always_ff @(posedge clock) begin
        if (state == LOAD) begin
            base_x   <= origin_x + offs_x;
            base_y   <= origin_y + offs_y;
            colour_q <= shp_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == LOAD) begin
            err_q <= oob;
        end
    end

    pixel_scanner #(
        .XW (X_W),
        .YW (Y_W)
    ) u_scanner (
        .clock  (clock),
        .reset  (reset),
        .load   (state == LOAD),
        .width  (shp_w),
        .height (shp_h),
        .enable (state == DRAW),
        .px     (px),
        .py     (py),
        .last   (scan_last)
    );

    assign pix_x = base_x + px;
    assign pix_y = base_y + py;

    // Remembers the last written pixel so outputs stay put when plot=0
    always_ff @(posedge clock) begin
        if (reset) begin
            x_hold      <= '0;
            y_hold      <= '0;
            colour_hold <= '0;
        end else if (state == DRAW) begin
            x_hold      <= pix_x;
            y_hold      <= pix_y;
            colour_hold <= colour_q;
        end
    end

    assign busy   = (state != IDLE);
    assign plot   = (state == DRAW);
    assign done   = (state == DONE);
    assign err    = (state == DONE) && err_q;
    assign x      = plot ? pix_x    : x_hold;
    assign y      = plot ? pix_y    : y_hold;
    assign colour = plot ? colour_q : colour_hold;

endmodule

// File: tb/tb_tile_renderer.sv
module tb_tile_renderer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] address;
    logic [7:0] position;
    logic       busy;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       done;
    logic       err;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t sb[$];
    pix_t last_pix;
    int   n_assert = 0;
    int   n_fail   = 0;

    tile_renderer #(
        .TILE_W    (16),
        .TILE_H    (12),
        .GRID_COLS (10),
        .GRID_ROWS (10),
        .X_W       (8),
        .Y_W       (7),
        .COLOUR_W  (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .address  (address),
        .position (position),
        .busy     (busy),
        .plot     (plot),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_rect(input int x0, input int y0, input int w, input int h, input int c);
        pix_t p;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                p.px = x0 + xx;
                p.py = y0 + yy;
                p.pc = c;
                sb.push_back(p);
            end
        end
    endtask

    // Entered just after a falling edge; cycle 0 is the cycle start is high.
    task automatic run_cell(input logic [7:0] a, input logic [7:0] p, input logic exp_err,
                            input int area, input int poke_cycle);
        int   cyc;
        int   first_plot;
        int   nplots;
        bit   seen_done;
        pix_t e;
        first_plot = -1;
        nplots     = 0;
        seen_done  = 0;
        address    = a;
        position   = p;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        while (!seen_done && cyc < 400) begin
            if (cyc == poke_cycle) begin
                start    = 1'b1;
                address  = 8'h55;
                position = 8'h80;
            end else begin
                start = 1'b0;
            end
            check("busy_during", {31'b0, busy}, 1);
            if (plot) begin
                nplots++;
                if (first_plot < 0) first_plot = cyc;
                if (sb.size() == 0) begin
                    check("extra_plot", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pix_x", {24'b0, x}, e.px);
                    check("pix_y", {25'b0, y}, e.py);
                    check("pix_colour", {29'b0, colour}, e.pc);
                    last_pix = e;
                end
            end
            if (done) begin
                seen_done = 1;
                check("done_cycle", cyc, 2 + area);
                check("err_flag", {31'b0, err}, {31'b0, exp_err});
                check("plot_at_done", {31'b0, plot}, 0);
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", {31'b0, seen_done}, 1);
        check("plot_count", nplots, area);
        check("sb_empty", sb.size(), 0);
        sb.delete();
        if (area > 0) check("first_plot_cycle", first_plot, 2);
        // One cycle after done
        check("busy_after", {31'b0, busy}, 0);
        check("done_after", {31'b0, done}, 0);
        check("plot_after", {31'b0, plot}, 0);
        if (area > 0) begin
            check("x_hold", {24'b0, x}, last_pix.px);
            check("y_hold", {25'b0, y}, last_pix.py);
            check("colour_hold", {29'b0, colour}, last_pix.pc);
        end
    endtask

    initial begin
        int nplots;
        int guard;
        reset    = 1'b1;
        start    = 1'b0;
        address  = 8'h00;
        position = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_plot", {31'b0, plot}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_x", {24'b0, x}, 0);
        check("rst_y", {25'b0, y}, 0);
        check("rst_colour", {29'b0, colour}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Wall, with a start pulse while busy that must be ignored
        push_rect(48, 24, 16, 12, 3);
        run_cell(8'h23, 8'h80, 1'b0, 192, 50);
        check("no_restart_busy", {31'b0, busy}, 0);

        push_rect(4, 2, 8, 8, 5);
        run_cell(8'h00, 8'h40, 1'b0, 64, -1);

        push_rect(4, 2, 8, 8, 4);
        run_cell(8'h00, 8'h20, 1'b0, 64, -1);

        push_rect(16, 17, 16, 2, 6);
        run_cell(8'h11, 8'h14, 1'b0, 32, -1);

        push_rect(7, 0, 2, 12, 6);
        run_cell(8'h00, 8'h18, 1'b0, 24, -1);

        // Off-grid row, then off-grid column
        run_cell(8'hA0, 8'h80, 1'b1, 0, -1);
        run_cell(8'h0A, 8'h40, 1'b1, 0, -1);

        // Unknown code erases the full tile
        push_rect(144, 108, 16, 12, 0);
        run_cell(8'h99, 8'h01, 1'b0, 192, -1);

        // Reset at the 10th plot abandons the draw
        address  = 8'h23;
        position = 8'h80;
        start    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        nplots = 0;
        guard  = 0;
        while (nplots < 10 && guard < 50) begin
            if (plot) nplots++;
            if (nplots < 10) @(negedge clock);
            guard++;
        end
        check("reached_10th_plot", nplots, 10);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_plot", {31'b0, plot}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        check("mid_rst_x", {24'b0, x}, 0);
        check("mid_rst_y", {25'b0, y}, 0);
        check("mid_rst_colour", {29'b0, colour}, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("post_rst_done", {31'b0, done}, 0);
            check("post_rst_plot", {31'b0, plot}, 0);
        end

        // Renderer still works after the abandoned draw
        push_rect(4, 2, 8, 8, 5);
        run_cell(8'h00, 8'h40, 1'b0, 64, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
